// File: rtl/rom_dump_streamer.sv
// rom_dump_streamer: walks every address of an IP3601/IP3604 bipolar PROM,
// waits for the data bus to settle, samples it and sends each byte as an
// 8N1 UART frame. The dump can be aborted, but a frame that has started is
// always finished.
module rom_dump_streamer #(
  parameter int BAUD_DIVISOR  = 434,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       chip_type,
  input  logic [7:0] data_line_in,
  output logic [8:0] address_line,
  output logic       chip_enable,
  output logic       uart_tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE, SETUP, SETTLE, SAMPLE, SEND, NEXT, FINISH
  } state_t;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0] BAUD_LAST   = 16'(BAUD_DIVISOR - 1);

  state_t      state, next_state;
  logic [8:0]  addr;
  logic        chip_sel;     // chip type latched when the dump starts
  logic [7:0]  tx_byte;
  logic [7:0]  settle_cnt;
  logic [15:0] baud_cnt;
  logic [3:0]  bit_idx;      // 0 = start bit, 1..8 = data, 9 = stop bit
  logic        abort_pend;
  logic        tx_q;
  logic [8:0]  last_addr;
  logic        bit_end;
  logic        frame_end;

  assign last_addr = chip_sel ? 9'd511 : 9'd255;
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign frame_end = bit_end && (bit_idx == 4'd9);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state decode; abort is honoured at once except inside a frame.
  // NOTE: next_state gets a default before the case so no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start && !abort) next_state = SETUP;
      SETUP:   next_state = abort ? FINISH : SETTLE;
      SETTLE:  if (abort)                          next_state = FINISH;
               else if (settle_cnt == SETTLE_LAST) next_state = SAMPLE;
      SAMPLE:  next_state = abort ? FINISH : SEND;
      SEND:    if (frame_end) next_state = (abort_pend || abort) ? FINISH : NEXT;
      NEXT:    next_state = (abort || addr == last_addr) ? FINISH : SETTLE;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Address counter, settle timer, UART shifter and pending-abort flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr       <= '0;
      chip_sel   <= 1'b0;
      tx_byte    <= '0;
      settle_cnt <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      abort_pend <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      if (state == IDLE && next_state == SETUP) chip_sel <= chip_type;

      if (state == IDLE || next_state == FINISH)     addr <= '0;
      else if (state == NEXT && next_state == SETTLE) addr <= addr + 9'd1;

      settle_cnt <= (state == SETTLE) ? settle_cnt + 8'd1 : 8'd0;

      if (state == SEND && abort)  abort_pend <= 1'b1;
      else if (state != SEND)      abort_pend <= 1'b0;

      if (state == SAMPLE && next_state == SEND) begin
        tx_byte  <= chip_sel ? data_line_in : {4'b0000, data_line_in[3:0]};
        tx_q     <= 1'b0;
        baud_cnt <= '0;
        bit_idx  <= '0;
      end else if (state == SEND) begin
        if (bit_end) begin
          baud_cnt <= '0;
          bit_idx  <= bit_idx + 4'd1;
          // Next level on the line: data bit, then stop bit / idle high.
          tx_q     <= (bit_idx < 4'd8) ? tx_byte[bit_idx[2:0]] : 1'b1;
        end else begin
          baud_cnt <= baud_cnt + 16'd1;
        end
      end else begin
        tx_q <= 1'b1;
      end
    end
  end

  assign address_line = addr;
  assign chip_enable  = (state == SETUP) || (state == SETTLE) || (state == SAMPLE);
  assign uart_tx      = tx_q;
  assign busy         = (state != IDLE);
  assign done         = (state == FINISH);

endmodule

// File: tb/tb_rom_dump_streamer.sv
// Directed bench for rom_dump_streamer with BAUD_DIVISOR=4, SETTLE_CYCLES=2.
module tb_rom_dump_streamer;

  localparam int B = 4;
  localparam int S = 2;
  localparam int K = S + 1 + 10 * B + 1;   // cycles per address

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, chip_type;
  logic [7:0] data_line_in;
  logic [8:0] address_line;
  logic       chip_enable, uart_tx, busy, done;

  logic       rom_mode;
  logic [7:0] const_data;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] frames[$];
  int frame_err = 0;
  int ce_err = 0;
  int done_cnt = 0;
  int done_wide = 0;
  int max_addr = 0;
  logic done_prev = 1'b0;

  rom_dump_streamer #(.BAUD_DIVISOR(B), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset_n(rst_n), .start(start), .abort(abort),
    .chip_type(chip_type), .data_line_in(data_line_in),
    .address_line(address_line), .chip_enable(chip_enable),
    .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // ROM model: pattern data or a constant.
  assign data_line_in = rom_mode ? (address_line[7:0] ^ 8'hA5) : const_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Done pulse and address range monitor.
  always @(negedge clk) begin
    if (done === 1'b1 && done_prev !== 1'b1) done_cnt++;
    if (done === 1'b1 && done_prev === 1'b1) done_wide++;
    done_prev <= done;
    if (busy === 1'b1 && int'(address_line) > max_addr) max_addr = int'(address_line);
  end

  // UART receiver: captures all 10*B cycles of a frame and checks every bit is flat.
  initial begin : uart_mon
    logic [10*B-1:0] s;
    logic            ok;
    logic            v;
    logic [7:0]      b;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        ok = 1'b1;
        s = '0;
        if (chip_enable !== 1'b0) ce_err++;
        for (int i = 1; i < 10 * B; i++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) ok = 1'b0;
          s[i] = uart_tx;
          if (chip_enable !== 1'b0) ce_err++;
        end
        if (ok) begin
          b = '0;
          for (int k = 0; k < 10; k++) begin
            v = s[k*B];
            for (int j = 1; j < B; j++) if (s[k*B+j] !== v) frame_err++;
            if (k == 0 && v !== 1'b0) frame_err++;
            if (k == 9 && v !== 1'b1) frame_err++;
            if (k >= 1 && k <= 8) b[k-1] = v;
          end
          frames.push_back(b);
        end
      end
    end
  end

  // Pulse start, optionally flip chip_type mid-dump, count cycles until done.
  task automatic run_dump(input int limit, input int flip_at, output int cycles);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < limit) begin
      if (cycles == flip_at) chip_type = ~chip_type;
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin : stim
    int cycles, d0, fe0, bad;
    logic seen_busy, seen_low;
    logic [7:0] exp_b;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; chip_type = 1'b0;
    rom_mode = 1'b1; const_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(address_line), 0);
    check("rst_ce",   32'(chip_enable), 0);
    check("rst_tx",   32'(uart_tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full IP3604 dump with pattern data.
    chip_type = 1'b1; frames.delete(); max_addr = 0; d0 = done_cnt; fe0 = frame_err;
    run_dump(30000, 0, cycles);
    check("t1_cycles", 32'(cycles), 32'(2 + 512 * K));
    @(negedge clk);
    check("t1_busy_after", 32'(busy), 0);
    check("t1_frames", 32'(frames.size()), 512);
    check("t1_byte0", 32'(frames[0]), 32'h A5);
    check("t1_byte1", 32'(frames[1]), 32'h A4);
    check("t1_byte2", 32'(frames[2]), 32'h A7);
    bad = 0;
    for (int i = 0; i < frames.size(); i++) begin
      exp_b = 8'(i) ^ 8'hA5;
      if (frames[i] !== exp_b) bad++;
    end
    check("t1_bytes_bad", 32'(bad), 0);
    check("t1_done_pulses", 32'(done_cnt - d0), 1);
    check("t1_frame_err", 32'(frame_err - fe0), 0);
    check("t1_max_addr", 32'(max_addr), 511);

    // IP3601 dump with constant bus 8'hF3: only the low nibble is sent.
    chip_type = 1'b0; rom_mode = 1'b0; const_data = 8'hF3;
    frames.delete(); max_addr = 0; d0 = done_cnt;
    run_dump(15000, 0, cycles);
    check("t2_cycles", 32'(cycles), 32'(2 + 256 * K));
    @(negedge clk);
    check("t2_frames", 32'(frames.size()), 256);
    bad = 0;
    for (int i = 0; i < frames.size(); i++) if (frames[i] !== 8'h03) bad++;
    check("t2_bytes_bad", 32'(bad), 0);
    check("t2_max_addr", 32'(max_addr), 255);
    check("t2_done_pulses", 32'(done_cnt - d0), 1);

    // chip_type flipped 1 -> 0 mid-dump: still 512 addresses of 8-bit data.
    chip_type = 1'b1; rom_mode = 1'b1; frames.delete(); d0 = done_cnt;
    run_dump(30000, 100, cycles);
    check("t3_cycles", 32'(cycles), 32'(2 + 512 * K));
    @(negedge clk);
    check("t3_frames", 32'(frames.size()), 512);
    bad = 0;
    for (int i = 0; i < frames.size(); i++) begin
      exp_b = 8'(i) ^ 8'hA5;
      if (frames[i] !== exp_b) bad++;
    end
    check("t3_bytes_bad", 32'(bad), 0);

    // Abort during data bit 3 of the frame for address 5.
    chip_type = 1'b1; frames.delete(); d0 = done_cnt; fe0 = frame_err;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cycles = 1;
    while (!(address_line == 9'd5 && uart_tx == 1'b0) && cycles < 1000) begin
      @(negedge clk); cycles++;
    end
    repeat (16) begin @(negedge clk); cycles++; end
    abort = 1'b1;
    @(negedge clk); cycles++;
    abort = 1'b0;
    while (done !== 1'b1 && cycles < 2000) begin @(negedge clk); cycles++; end
    check("t4_cycles", 32'(cycles), 32'(1 + 5 * K + S + 1 + 10 * B + 1));
    @(negedge clk);
    check("t4_busy_after", 32'(busy), 0);
    check("t4_frames", 32'(frames.size()), 6);
    check("t4_last_byte", 32'(frames[frames.size()-1]), 32'h A0);
    check("t4_frame_err", 32'(frame_err - fe0), 0);
    check("t4_done_pulses", 32'(done_cnt - d0), 1);

    // Abort while settling: FINISH on the next cycle, no frame.
    frames.delete(); d0 = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("t5_done", 32'(done), 1);
    check("t5_addr_finish", 32'(address_line), 0);
    repeat (3) @(negedge clk);
    check("t5_busy_after", 32'(busy), 0);
    check("t5_frames", 32'(frames.size()), 0);
    check("t5_done_pulses", 32'(done_cnt - d0), 1);

    // start and abort together in IDLE: nothing happens.
    d0 = done_cnt; seen_busy = 1'b0; seen_low = 1'b0;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    repeat (6) begin
      seen_busy |= busy;
      seen_low  |= ~uart_tx;
      @(negedge clk);
    end
    check("t6_busy_seen", 32'(seen_busy), 0);
    check("t6_tx_low_seen", 32'(seen_low), 0);
    check("t6_done_pulses", 32'(done_cnt - d0), 0);

    // Reset during data bit 4 of address 10, then restart from address 0.
    chip_type = 1'b1; frames.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cycles = 1;
    while (!(address_line == 9'd10 && uart_tx == 1'b0) && cycles < 1000) begin
      @(negedge clk); cycles++;
    end
    repeat (20) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t7_tx", 32'(uart_tx), 1);
    check("t7_busy", 32'(busy), 0);
    check("t7_addr", 32'(address_line), 0);
    check("t7_ce", 32'(chip_enable), 0);
    repeat (45) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t7_no_resume", 32'(busy), 0);
    frames.delete(); d0 = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cycles = 1;
    while (frames.size() < 1 && cycles < 200) begin @(negedge clk); cycles++; end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    cycles = 0;
    while (done_cnt == d0 && cycles < 200) begin @(negedge clk); cycles++; end
    check("t7_restart_done", 32'(done_cnt - d0), 1);
    check("t7_restart_frames", 32'(frames.size()), 1);
    check("t7_restart_byte", 32'(frames[0]), 32'h A5);
    check("done_width", 32'(done_wide), 0);
    check("ce_during_send", 32'(ce_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
